ex_operand_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the 32-bit ALU in the pipelined MIPS-lite core. It registers decoded instruction fields at the ID/EX boundary and decodes ALU control into the 3-bit ALU op code. It forwards operands from the MEM and WB stages and drives the ALU's two operands and op code. It also detects load-use hazards and inserts bubbles on stall or flush.

---
 rtl/mips_pkg.sv | 84 ++++++++
 rtl/ex_operand_stage_if.sv | 55 +++++
 rtl/forward_unit.sv | 33 +++
 rtl/ex_operand_stage.sv | 90 +++++++++
 tb/tb_ex_operand_stage.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-lite EX operand stage.
package mips_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RegW  = 5;

    // ALU op codes; SUB and SLT are the B-invert codes.
    typedef enum logic [2:0] {
        AluAnd = 3'b000,
        AluOr  = 3'b001,
        AluAdd = 3'b010,
        AluSub = 3'b011,
        AluSlt = 3'b100
    } alu_sig_e;

    // Main-decoder alu_op encodings.
    typedef enum logic [1:0] {
        OpAdd   = 2'b00,
        OpSub   = 2'b01,
        OpRtype = 2'b10,
        OpRsvd  = 2'b11
    } alu_op_e;

    // R-type funct codes.
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    typedef struct packed {
        alu_sig_e sig;
        logic     illegal;
    } alu_dec_t;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic [RegW-1:0]  rs;
        logic [RegW-1:0]  rt;
        logic [DataW-1:0] rs_data;
        logic [DataW-1:0] rt_data;
        logic [DataW-1:0] imm;
        logic             alu_src;
        logic [RegW-1:0]  dest;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             illegal;
        alu_sig_e         alu_sig;
    } ex_reg_t;

    // Unknown funct or reserved alu_op falls back to ADD and is flagged illegal.
    function automatic alu_dec_t decode_alu(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_dec_t dec;
        dec.sig     = AluAdd;
        dec.illegal = 1'b0;
        case (alu_op)
            OpAdd: dec.sig = AluAdd;
            OpSub: dec.sig = AluSub;
            OpRtype: begin
                case (funct)
                    FunctAdd: dec.sig = AluAdd;
                    FunctSub: dec.sig = AluSub;
                    FunctAnd: dec.sig = AluAnd;
                    FunctOr:  dec.sig = AluOr;
                    FunctSlt: dec.sig = AluSlt;
                    default:  dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        return dec;
    endfunction

    // Bubble and reset value: everything zero, ALU code ADD.
    function automatic ex_reg_t ex_bubble();
        ex_reg_t b;
        b         = '0;
        b.alu_sig = AluAdd;
        return b;
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID-side, forwarding and EX-side signals of the operand stage.
interface ex_operand_stage_if;
    import mips_pkg::*;

    logic [RegW-1:0]  id_rs;
    logic [RegW-1:0]  id_rt;
    logic [RegW-1:0]  id_rd;
    logic [DataW-1:0] id_rs_data;
    logic [DataW-1:0] id_rt_data;
    logic [DataW-1:0] id_imm;
    logic [1:0]       id_alu_op;
    logic [5:0]       id_funct;
    logic             id_alu_src;
    logic             id_reg_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_mem_to_reg;
    logic             flush;
    logic             mem_reg_write;
    logic [RegW-1:0]  mem_rd;
    logic [DataW-1:0] mem_result;
    logic             wb_reg_write;
    logic [RegW-1:0]  wb_rd;
    logic [DataW-1:0] wb_data;

    logic [DataW-1:0] alu_dataA;
    logic [DataW-1:0] alu_dataB;
    logic [2:0]       alu_signal;
    logic [DataW-1:0] ex_store_data;
    logic [RegW-1:0]  ex_dest;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             ex_illegal;
    logic             load_use_stall;

    modport master (
        output id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_alu_op, id_funct,
               id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        input  alu_dataA, alu_dataB, alu_signal, ex_store_data, ex_dest, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, load_use_stall
    );

    modport slave (
        input  id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_alu_op, id_funct,
               id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        output alu_dataA, alu_dataB, alu_signal, ex_store_data, ex_dest, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, load_use_stall
    );

endinterface

// File: rtl/forward_unit.sv
// Selects the freshest value of one source register: MEM, then WB, then register file.
module forward_unit
    import mips_pkg::*;
(
    input  logic [RegW-1:0]  i_idx,
    input  logic [DataW-1:0] i_reg_data,
    input  logic             i_mem_reg_write,
    input  logic [RegW-1:0]  i_mem_rd,
    input  logic [DataW-1:0] i_mem_result,
    input  logic             i_wb_reg_write,
    input  logic [RegW-1:0]  i_wb_rd,
    input  logic [DataW-1:0] i_wb_data,
    output logic [DataW-1:0] o_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hard-wired zero, so a pending write to it must never forward.
    assign w_mem_hit = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_idx);
    assign w_wb_hit  = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_idx);

    // Priority mux: the younger MEM result wins over WB.
    always_comb begin
        o_data = i_reg_data;
        if (w_mem_hit) begin
            o_data = i_mem_result;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register, ALU control decode, operand forwarding and load-use stall detection.
module ex_operand_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ex_operand_stage_if.slave bus
);

    ex_reg_t          r_ex;
    ex_reg_t          w_ex_next;
    alu_dec_t         w_dec;
    logic             w_stall;
    logic [DataW-1:0] w_fwd_rs;
    logic [DataW-1:0] w_fwd_rt;

    // A load in EX cannot supply data before WB; rt only matters when it is actually read.
    assign w_stall = r_ex.mem_read && (r_ex.dest != '0) &&
                     ((r_ex.dest == bus.id_rs) ||
                      ((r_ex.dest == bus.id_rt) && (!bus.id_alu_src || bus.id_mem_write)));

    assign w_dec = decode_alu(bus.id_alu_op, bus.id_funct);

    // Next ID/EX contents: a bubble on flush or stall, otherwise the decoded instruction.
    always_comb begin
        w_ex_next = ex_bubble();
        if (!(bus.flush || w_stall)) begin
            w_ex_next.rs         = bus.id_rs;
            w_ex_next.rt         = bus.id_rt;
            w_ex_next.rs_data    = bus.id_rs_data;
            w_ex_next.rt_data    = bus.id_rt_data;
            w_ex_next.imm        = bus.id_imm;
            w_ex_next.alu_src    = bus.id_alu_src;
            w_ex_next.dest       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            // Illegal ops must not modify architectural state.
            w_ex_next.reg_write  = bus.id_reg_write && !w_dec.illegal;
            w_ex_next.mem_write  = bus.id_mem_write && !w_dec.illegal;
            w_ex_next.mem_read   = bus.id_mem_read;
            w_ex_next.mem_to_reg = bus.id_mem_to_reg;
            w_ex_next.illegal    = w_dec.illegal;
            w_ex_next.alu_sig    = w_dec.sig;
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= ex_bubble();
        end else begin
            r_ex <= w_ex_next;
        end
    end

    forward_unit u_fwd_rs (
        .i_idx           (r_ex.rs),
        .i_reg_data      (r_ex.rs_data),
        .i_mem_reg_write (bus.mem_reg_write),
        .i_mem_rd        (bus.mem_rd),
        .i_mem_result    (bus.mem_result),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_rd         (bus.wb_rd),
        .i_wb_data       (bus.wb_data),
        .o_data          (w_fwd_rs)
    );

    forward_unit u_fwd_rt (
        .i_idx           (r_ex.rt),
        .i_reg_data      (r_ex.rt_data),
        .i_mem_reg_write (bus.mem_reg_write),
        .i_mem_rd        (bus.mem_rd),
        .i_mem_result    (bus.mem_result),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_rd         (bus.wb_rd),
        .i_wb_data       (bus.wb_data),
        .o_data          (w_fwd_rt)
    );

    assign bus.alu_dataA      = w_fwd_rs;
    assign bus.alu_dataB      = r_ex.alu_src ? r_ex.imm : w_fwd_rt;
    assign bus.alu_signal     = r_ex.alu_sig;
    assign bus.ex_store_data  = w_fwd_rt;
    assign bus.ex_dest        = r_ex.dest;
    assign bus.ex_reg_write   = r_ex.reg_write;
    assign bus.ex_mem_read    = r_ex.mem_read;
    assign bus.ex_mem_write   = r_ex.mem_write;
    assign bus.ex_mem_to_reg  = r_ex.mem_to_reg;
    assign bus.ex_illegal     = r_ex.illegal;
    assign bus.load_use_stall = w_stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed table, hazard sequences, random vs model.
module tb_ex_operand_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_operand_stage_if bus_if ();

    ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, flush;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_result;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } stim_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [31:0] a, b, st;
        logic [2:0]  sig;
        logic        ill, rw;
    } vec_t;

    // Reference view of what the stage holds for the instruction now in EX.
    typedef struct packed {
        logic [4:0]  rs, rt;
        logic [31:0] rs_data, rt_data, imm;
        logic        alu_src;
        logic [4:0]  dest;
        logic        rw, mr, mw, m2r, ill;
        logic [2:0]  sig;
    } mdl_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    vec_t  vecs[$];
    mdl_t  m;
    logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                               6'b000111};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [31:0] rsd,
                                 input logic [31:0] rtd);
        stim_t s = '0;
        s.alu_op    = op;
        s.funct     = fn;
        s.rs        = rs;
        s.rt        = rt;
        s.rd        = 5'd9;
        s.rs_data   = rsd;
        s.rt_data   = rtd;
        s.imm       = 32'h0000_0040;
        s.reg_dst   = 1'b1;
        s.reg_write = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus_if.id_rs         = s.rs;
        bus_if.id_rt         = s.rt;
        bus_if.id_rd         = s.rd;
        bus_if.id_rs_data    = s.rs_data;
        bus_if.id_rt_data    = s.rt_data;
        bus_if.id_imm        = s.imm;
        bus_if.id_alu_op     = s.alu_op;
        bus_if.id_funct      = s.funct;
        bus_if.id_alu_src    = s.alu_src;
        bus_if.id_reg_dst    = s.reg_dst;
        bus_if.id_reg_write  = s.reg_write;
        bus_if.id_mem_read   = s.mem_read;
        bus_if.id_mem_write  = s.mem_write;
        bus_if.id_mem_to_reg = s.mem_to_reg;
        bus_if.flush         = s.flush;
        bus_if.mem_reg_write = s.mem_we;
        bus_if.mem_rd        = s.mem_rd;
        bus_if.mem_result    = s.mem_result;
        bus_if.wb_reg_write  = s.wb_we;
        bus_if.wb_rd         = s.wb_rd;
        bus_if.wb_data       = s.wb_data;
    endtask

    task automatic add_vec(input string name, input stim_t s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] st, input logic [2:0] sig,
                           input logic ill, input logic rw);
        vec_t v;
        v.name = name; v.s = s; v.a = a; v.b = b; v.st = st; v.sig = sig; v.ill = ill; v.rw = rw;
        vecs.push_back(v);
    endtask

    // {illegal, alu code} straight from the decode table.
    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return {1'b0, 3'b010};
        if (op == 2'd1) return {1'b0, 3'b011};
        if (op == 2'd2) begin
            if (fn == 6'h20) return {1'b0, 3'b010};
            if (fn == 6'h22) return {1'b0, 3'b011};
            if (fn == 6'h24) return {1'b0, 3'b000};
            if (fn == 6'h25) return {1'b0, 3'b001};
            if (fn == 6'h2A) return {1'b0, 3'b100};
        end
        return {1'b1, 3'b010};
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] d,
                                            input stim_t s);
        if (s.mem_we && s.mem_rd != 0 && s.mem_rd == idx) return s.mem_result;
        if (s.wb_we && s.wb_rd != 0 && s.wb_rd == idx) return s.wb_data;
        return d;
    endfunction

    function automatic mdl_t bubble();
        mdl_t b = '0;
        b.sig = 3'b010;
        return b;
    endfunction

    initial begin
        stim_t s, s2;
        logic [3:0] dec;
        logic exp_stall, r;
        logic [31:0] rt_f;

        // Reset, with live-looking ID inputs that must be ignored.
        s = mk(2'b10, 6'b101010, 5'd3, 5'd4, 32'h55, 32'h66);
        s.mem_read = 1'b1; s.flush = 1'b1;
        apply(s);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dataA", bus_if.alu_dataA, 32'h0);
        check("rst_dataB", bus_if.alu_dataB, 32'h0);
        check("rst_signal", bus_if.alu_signal, 3'b010);
        check("rst_dest", bus_if.ex_dest, 5'd0);
        check("rst_ctrl", {bus_if.ex_reg_write, bus_if.ex_mem_read, bus_if.ex_mem_write,
                           bus_if.ex_mem_to_reg, bus_if.ex_illegal}, 5'b0);
        check("rst_store", bus_if.ex_store_data, 32'h0);
        check("rst_stall", bus_if.load_use_stall, 1'b0);
        rst = 1'b0;

        // Directed table.
        add_vec("slt", mk(2'b10, 6'b101010, 5'd1, 5'd2, 32'd5, 32'd9), 5, 9, 9, 3'b100, 0, 1);
        s = mk(2'b10, 6'b100000, 5'd3, 5'd5, 32'h99, 32'h7);
        s.mem_we = 1; s.mem_rd = 3; s.mem_result = 32'h11;
        s.wb_we = 1; s.wb_rd = 3; s.wb_data = 32'h22;
        add_vec("dbl_hazard_mem", s, 32'h11, 7, 7, 3'b010, 0, 1);
        s.mem_rd = 0;
        add_vec("dbl_hazard_wb", s, 32'h22, 7, 7, 3'b010, 0, 1);
        add_vec("illegal_funct", mk(2'b10, 6'b000111, 5'd1, 5'd2, 32'hA, 32'hB),
                32'hA, 32'hB, 32'hB, 3'b010, 1, 0);
        add_vec("rsvd_op", mk(2'b11, 6'b100000, 5'd1, 5'd2, 32'h1, 32'h2), 1, 2, 2, 3'b010, 1, 0);
        s = mk(2'b00, 6'b000000, 5'd2, 5'd3, 32'h100, 32'h55);
        s.alu_src = 1; s.imm = 32'hFFFF_FFF0;
        add_vec("lw_imm", s, 32'h100, 32'hFFFF_FFF0, 32'h55, 3'b010, 0, 1);
        add_vec("beq_sub", mk(2'b01, 6'b100100, 5'd6, 5'd7, 32'd3, 32'd3), 3, 3, 3, 3'b011, 0, 1);
        add_vec("and", mk(2'b10, 6'b100100, 5'd1, 5'd2, 32'hF0, 32'h3C), 32'hF0, 32'h3C, 32'h3C,
                3'b000, 0, 1);
        add_vec("or", mk(2'b10, 6'b100101, 5'd1, 5'd2, 32'hF0, 32'h3C), 32'hF0, 32'h3C, 32'h3C,
                3'b001, 0, 1);
        add_vec("sub_r", mk(2'b10, 6'b100010, 5'd1, 5'd2, 32'h8, 32'h3), 8, 3, 3, 3'b011, 0, 1);
        s = mk(2'b10, 6'b100000, 5'd0, 5'd0, 32'h1234, 32'h5678);
        s.mem_we = 1; s.mem_rd = 0; s.mem_result = 32'hBAD;
        s.wb_we = 1; s.wb_rd = 0; s.wb_data = 32'hBAD2;
        add_vec("r0_no_fwd", s, 32'h1234, 32'h5678, 32'h5678, 3'b010, 0, 1);
        s = mk(2'b10, 6'b100000, 5'd1, 5'd7, 32'h1, 32'h2);
        s.wb_we = 1; s.wb_rd = 7; s.wb_data = 32'h77;
        add_vec("wb_rt", s, 1, 32'h77, 32'h77, 3'b010, 0, 1);
        s = mk(2'b10, 6'b100000, 5'd4, 5'd2, 32'h1, 32'h2);
        s.mem_rd = 4; s.mem_result = 32'hBAD;
        s.wb_we = 1; s.wb_rd = 4; s.wb_data = 32'h44;
        add_vec("mem_we_off", s, 32'h44, 2, 2, 3'b010, 0, 1);
        s = mk(2'b00, 6'b0, 5'd1, 5'd6, 32'h1, 32'h2);
        s.alu_src = 1; s.mem_write = 1; s.imm = 32'h8;
        s.mem_we = 1; s.mem_rd = 6; s.mem_result = 32'h66;
        add_vec("sw_store_fwd", s, 1, 32'h8, 32'h66, 3'b010, 0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].s);
            #1;
            check({vecs[i].name, "_nostall"}, bus_if.load_use_stall, 1'b0);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_dataA"}, bus_if.alu_dataA, vecs[i].a);
            check({vecs[i].name, "_dataB"}, bus_if.alu_dataB, vecs[i].b);
            check({vecs[i].name, "_store"}, bus_if.ex_store_data, vecs[i].st);
            check({vecs[i].name, "_signal"}, bus_if.alu_signal, vecs[i].sig);
            check({vecs[i].name, "_illegal"}, bus_if.ex_illegal, vecs[i].ill);
            check({vecs[i].name, "_regwrite"}, bus_if.ex_reg_write, vecs[i].rw);
        end

        // Load-use: lw $4 enters EX, dependent add waits one cycle, then forwards from WB.
        s = mk(2'b00, 6'b0, 5'd2, 5'd4, 32'h10, 32'h0);
        s.alu_src = 1; s.reg_dst = 0; s.mem_read = 1; s.mem_to_reg = 1;
        apply(s);
        @(posedge clk); #1;
        check("lu_load_dest", bus_if.ex_dest, 5'd4);
        check("lu_load_memread", bus_if.ex_mem_read, 1'b1);
        s2 = mk(2'b10, 6'b100000, 5'd4, 5'd6, 32'hDEAD, 32'h6);
        apply(s2);
        #1;
        check("lu_stall", bus_if.load_use_stall, 1'b1);
        @(posedge clk); #1;
        check("lu_bubble_rw", bus_if.ex_reg_write, 1'b0);
        check("lu_bubble_dest", bus_if.ex_dest, 5'd0);
        check("lu_bubble_signal", bus_if.alu_signal, 3'b010);
        check("lu_bubble_dataA", bus_if.alu_dataA, 32'h0);
        check("lu_stall_one_cycle", bus_if.load_use_stall, 1'b0);
        s2.wb_we = 1; s2.wb_rd = 4; s2.wb_data = 32'hCAFE;
        apply(s2);
        @(posedge clk); #1;
        check("lu_fwd_wb", bus_if.alu_dataA, 32'hCAFE);
        check("lu_dep_rw", bus_if.ex_reg_write, 1'b1);
        check("lu_dep_dest", bus_if.ex_dest, 5'd9);

        // Flush together with a stall gives exactly one bubble.
        apply(s);
        @(posedge clk); #1;
        s2 = mk(2'b00, 6'b0, 5'd1, 5'd4, 32'h1, 32'h2);
        s2.mem_write = 1; s2.alu_src = 1; s2.flush = 1;
        apply(s2);
        #1;
        check("fs_stall", bus_if.load_use_stall, 1'b1);
        @(posedge clk); #1;
        check("fs_rw", bus_if.ex_reg_write, 1'b0);
        check("fs_mw", bus_if.ex_mem_write, 1'b0);
        check("fs_dest", bus_if.ex_dest, 5'd0);
        s2.flush = 0;
        apply(s2);
        #1;
        check("fs_single_bubble", bus_if.load_use_stall, 1'b0);
        @(posedge clk); #1;
        check("fs_capture_mw", bus_if.ex_mem_write, 1'b1);

        // Random stimulus against the reference model.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m = bubble();
        for (int it = 0; it < 400; it++) begin
            s = '0;
            s.rs = 5'($urandom_range(0, 7));
            s.rt = 5'($urandom_range(0, 7));
            s.rd = 5'($urandom_range(0, 7));
            s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
            s.alu_op = 2'($urandom_range(0, 3));
            s.funct = fn_tab[$urandom_range(0, 5)];
            s.alu_src = 1'($urandom); s.reg_dst = 1'($urandom); s.reg_write = 1'($urandom);
            s.mem_read = ($urandom_range(0, 2) == 0); s.mem_write = 1'($urandom);
            s.mem_to_reg = 1'($urandom); s.flush = ($urandom_range(0, 7) == 0);
            s.mem_we = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 7)); s.mem_result = $urandom;
            s.wb_we = 1'($urandom); s.wb_rd = 5'($urandom_range(0, 7)); s.wb_data = $urandom;
            r = ($urandom_range(0, 49) == 0);
            apply(s);
            rst = r;
            #1;
            exp_stall = m.mr && m.dest != 0 &&
                        (m.dest == s.rs || (m.dest == s.rt && (!s.alu_src || s.mem_write)));
            check("rnd_stall", bus_if.load_use_stall, exp_stall);
            @(posedge clk);
            if (r || s.flush || exp_stall) begin
                m = bubble();
            end else begin
                dec = ref_decode(s.alu_op, s.funct);
                m.rs = s.rs; m.rt = s.rt; m.rs_data = s.rs_data; m.rt_data = s.rt_data;
                m.imm = s.imm; m.alu_src = s.alu_src;
                m.dest = s.reg_dst ? s.rd : s.rt;
                m.ill = dec[3]; m.sig = dec[2:0];
                m.rw = s.reg_write && !dec[3];
                m.mw = s.mem_write && !dec[3];
                m.mr = s.mem_read; m.m2r = s.mem_to_reg;
            end
            #1;
            rt_f = ref_fwd(m.rt, m.rt_data, s);
            check("rnd_dataA", bus_if.alu_dataA, ref_fwd(m.rs, m.rs_data, s));
            check("rnd_dataB", bus_if.alu_dataB, m.alu_src ? m.imm : rt_f);
            check("rnd_store", bus_if.ex_store_data, rt_f);
            check("rnd_signal", bus_if.alu_signal, m.sig);
            check("rnd_dest", bus_if.ex_dest, m.dest);
            check("rnd_ctrl", {bus_if.ex_reg_write, bus_if.ex_mem_read, bus_if.ex_mem_write,
                               bus_if.ex_mem_to_reg, bus_if.ex_illegal},
                  {m.rw, m.mr, m.mw, m.m2r, m.ill});
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
